nh_lcd_line_feeder: RTL and testbench
=====================================

NH_LCD_LINE_FEEDER -- requirements
Module: nh_lcd_line_feeder

Interface
REQ-001 Parameter DATAS_WIDTH, default 24, pixel payload width; FIFO word is DATAS_WIDTH+1 bits.
REQ-002 clk  in  1  Clock; all logic on posedge clk.
REQ-003 rst  in  1  Reset: synchronous, active-high.
REQ-004 i_enable  in  1  Frame start permission; sampled only in IDLE.
REQ-005 i_image_width  in  32  Pixels per line.
REQ-006 i_image_height  in  32  Lines per frame.
REQ-007 i_unpack_pixels  in  1  0: one RGB888 pixel per word in [23:0]; 1: two RGB565 pixels per word.
REQ-008 i_pix_valid  in  1  Source word valid.
REQ-009 o_pix_ready  out  1  Word accepted when valid and ready are both high.
REQ-010 i_pix_data  in  32  Source word.
REQ-011 i_fifo_rdy  in  2  Ping-pong write buffers free.
REQ-012 o_fifo_act  out  2  One-hot buffer ownership.
REQ-013 o_fifo_stb  out  1  Write strobe.
REQ-014 i_fifo_size  in  24  Capacity of the owned buffer.
REQ-015 o_fifo_data  out  25  {last, R[7:0], G[7:0], B[7:0]}.
REQ-016 o_frame_done  out  1  One-cycle pulse at frame completion.
REQ-017 o_busy  out  1  High whenever state is not IDLE.

Function
REQ-018 States: IDLE, GET_FIFO, WRITE, RELEASE, FRAME_DONE.
REQ-019 IDLE -> GET_FIFO when i_enable=1, width>0 and height>0; otherwise remain in IDLE with no writes.
REQ-020 GET_FIFO: when i_fifo_rdy[0]=1, set o_fifo_act=2'b01; else when i_fifo_rdy[1]=1, set 2'b10; clear the buffer write count; go to WRITE.
REQ-021 o_pix_ready is high only in WRITE, with no pending unpacked upper half, pixel_cnt<width and buf_cnt<i_fifo_size.
REQ-022 An accepted word produces o_fifo_stb=1 with the first pixel on the next cycle (latency 1).
REQ-023 Unpack mode: pixel0=[15:0], written first; pixel1=[31:16], written on the following cycle while ready is held low.
REQ-024 Unpack mode: when pixel0 is the last pixel of a line (odd width), pixel1 is discarded.
REQ-025 RGB565 expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-026 o_fifo_data[24]=1 only on the pixel with index width-1 of each line.
REQ-027 After the last pixel of a line, go to RELEASE and increment line_cnt.
REQ-028 Buffer full (buf_cnt==i_fifo_size) before line end: go to RELEASE with no last bit, then GET_FIFO, and continue the same line in the next buffer.
REQ-029 RELEASE drives o_fifo_act=0 for exactly one cycle.
REQ-030 After RELEASE: go to GET_FIFO if line_cnt<height or the line is incomplete; otherwise go to FRAME_DONE.
REQ-031 FRAME_DONE: pulse o_frame_done, clear line_cnt and pixel_cnt, go to IDLE.
REQ-032 Deasserting i_enable mid-frame has no effect; the frame completes.
REQ-033 Changes to width, height or unpack mid-frame are undefined; these inputs are latched in IDLE on the start transition.
REQ-034 Counters are 32-bit; there is no wrap within a legal frame.

Reset
REQ-035 On rst: state=IDLE; o_fifo_act=0, o_fifo_stb=0, o_fifo_data=0, o_pix_ready=0, o_frame_done=0, o_busy=0; all counters and the unpack-pending flag cleared.
REQ-036 Reset mid-line abandons the line; the buffer is not released with a last marker.

Structure
REQ-037 State encodings, the last-bit index (24) and the buffer-select constants live in the shared nh_lcd_defines include.
REQ-038 One sub-module: nh_lcd_rgb565_expand (combinational 16->24 expansion).

Verification
REQ-039 width=4, height=2, packed mode, both buffers ready, words 0x00AABBCC..: 8 strobes; data[24]=1 on the 4th and 8th; act 01 then 10; one o_frame_done pulse.
REQ-040 Unpack mode, width=3, words 0xFFFF_F800, 0x1234_07E0: pixels 0xFF0000, 0xFFFFFF, 0x00FF00 with last=1; upper half 0x1234 dropped.
REQ-041 width=6, i_fifo_size=4: 4 writes with last=0, release, new buffer, 2 writes with the last one last=1.
REQ-042 i_fifo_rdy=00 held 10 cycles after enable: stays in GET_FIFO with act=0 and no strobes; proceeds within 1 cycle of rdy=01.
REQ-043 i_pix_valid toggled randomly: strobe count equals accepted pixel count; no strobes while valid is low.
REQ-044 rst asserted mid-line: next cycle all outputs are 0 and state is IDLE; a fresh frame then completes normally.

Source files
------------

// File: rtl/nh_lcd_line_feeder_pkg.sv
// Shared definitions for the LCD line feeder: FSM states, last-marker position
// and ping-pong buffer select codes.
package nh_lcd_line_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_FIFO,
        ST_WRITE,
        ST_RELEASE,
        ST_FRAME_DONE
    } state_t;

    localparam int unsigned LAST_BIT = 24;

    localparam logic [1:0] BUF_NONE = 2'b00;
    localparam logic [1:0] BUF_0    = 2'b01;
    localparam logic [1:0] BUF_1    = 2'b10;

endpackage

// File: rtl/nh_lcd_line_feeder_rgb565.sv
// Combinational RGB565 -> RGB888 expansion; the low bits of each channel are
// filled by replicating its most significant bits.
module nh_lcd_rgb565_expand (
    input  logic [15:0] pix565_i,
    output logic [23:0] pix888_o
);

    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

    assign r5 = pix565_i[15:11];
    assign g6 = pix565_i[10:5];
    assign b5 = pix565_i[4:0];

    assign pix888_o = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

endmodule

// File: rtl/nh_lcd_line_feeder.sv
// Streams source pixel words into ping-pong LCD line buffers, one line (or one
// buffer-full slice of a line) per buffer ownership, marking the last pixel of each line.
module nh_lcd_line_feeder
    import nh_lcd_line_feeder_pkg::*;
#(
    parameter int DATAS_WIDTH = LAST_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic [31:0]          i_image_width,
    input  logic [31:0]          i_image_height,
    input  logic                 i_unpack_pixels,
    input  logic                 i_pix_valid,
    output logic                 o_pix_ready,
    input  logic [31:0]          i_pix_data,
    input  logic [1:0]           i_fifo_rdy,
    output logic [1:0]           o_fifo_act,
    output logic                 o_fifo_stb,
    input  logic [23:0]          i_fifo_size,
    output logic [DATAS_WIDTH:0] o_fifo_data,
    output logic                 o_frame_done,
    output logic                 o_busy
);

    state_t state_q, state_d;

    logic [1:0]           act_q, act_d;
    logic                 stb_q, stb_d;
    logic [DATAS_WIDTH:0] data_q, data_d;
    logic [31:0]          width_q, width_d;
    logic [31:0]          height_q, height_d;
    logic                 unpack_q, unpack_d;
    logic [31:0]          pixel_cnt_q, pixel_cnt_d;
    logic [31:0]          line_cnt_q, line_cnt_d;
    logic [23:0]          buf_cnt_q, buf_cnt_d;
    logic                 pend_q, pend_d;
    logic [15:0]          hi_q, hi_d;
    logic                 line_end_q, line_end_d;

    logic        start;
    logic        accept;
    logic        buf_full;
    logic        line_full;
    logic        pend_write;
    logic        is_last;
    logic [15:0] exp_src;
    logic [23:0] exp_pix;

    assign start      = i_enable && (i_image_width != '0) && (i_image_height != '0);
    assign buf_full   = (buf_cnt_q >= i_fifo_size);
    assign line_full  = (pixel_cnt_q >= width_q);
    assign pend_write = (state_q == ST_WRITE) && pend_q && !buf_full;
    assign accept     = o_pix_ready && i_pix_valid;
    assign is_last    = (pixel_cnt_q == width_q - 32'd1);

    // A pending upper half is expanded through the same converter as a fresh lower half.
    assign exp_src = pend_q ? hi_q : i_pix_data[15:0];

    nh_lcd_rgb565_expand u_expand (
        .pix565_i (exp_src),
        .pix888_o (exp_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GET_FIFO;
                end
            end
            ST_GET_FIFO: begin
                if (i_fifo_rdy != BUF_NONE) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (line_full || buf_full) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!line_end_q || (line_cnt_q < height_q)) begin
                    state_d = ST_GET_FIFO;
                end else begin
                    state_d = ST_FRAME_DONE;
                end
            end
            ST_FRAME_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy       = (state_q != ST_IDLE);
        o_frame_done = (state_q == ST_FRAME_DONE);
        o_pix_ready  = (state_q == ST_WRITE) && !pend_q &&
                       (pixel_cnt_q < width_q) && (buf_cnt_q < i_fifo_size);
    end

    always_comb begin
        act_d       = act_q;
        stb_d       = 1'b0;
        data_d      = data_q;
        width_d     = width_q;
        height_d    = height_q;
        unpack_d    = unpack_q;
        pixel_cnt_d = pixel_cnt_q;
        line_cnt_d  = line_cnt_q;
        buf_cnt_d   = buf_cnt_q;
        pend_d      = pend_q;
        hi_d        = hi_q;
        line_end_d  = line_end_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_d     = i_image_width;
                    height_d    = i_image_height;
                    unpack_d    = i_unpack_pixels;
                    pixel_cnt_d = '0;
                    line_cnt_d  = '0;
                end
            end
            ST_GET_FIFO: begin
                buf_cnt_d = '0;
                if (i_fifo_rdy[0]) begin
                    act_d = BUF_0;
                end else if (i_fifo_rdy[1]) begin
                    act_d = BUF_1;
                end
            end
            ST_WRITE: begin
                if (pend_write) begin
                    stb_d       = 1'b1;
                    data_d      = {is_last, exp_pix};
                    pixel_cnt_d = pixel_cnt_q + 32'd1;
                    buf_cnt_d   = buf_cnt_q + 24'd1;
                    pend_d      = 1'b0;
                end else if (accept) begin
                    stb_d       = 1'b1;
                    data_d      = {is_last, unpack_q ? exp_pix : i_pix_data[23:0]};
                    pixel_cnt_d = pixel_cnt_q + 32'd1;
                    buf_cnt_d   = buf_cnt_q + 24'd1;
                    // Upper half is only kept when it still belongs to this line.
                    if (unpack_q && (pixel_cnt_q + 32'd1 < width_q)) begin
                        pend_d = 1'b1;
                        hi_d   = i_pix_data[31:16];
                    end
                end else if (line_full || buf_full) begin
                    act_d      = BUF_NONE;
                    line_end_d = line_full;
                    if (line_full) begin
                        line_cnt_d  = line_cnt_q + 32'd1;
                        pixel_cnt_d = '0;
                    end
                end
            end
            ST_FRAME_DONE: begin
                line_cnt_d  = '0;
                pixel_cnt_d = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q       <= '0;
            stb_q       <= 1'b0;
            data_q      <= '0;
            width_q     <= '0;
            height_q    <= '0;
            unpack_q    <= 1'b0;
            pixel_cnt_q <= '0;
            line_cnt_q  <= '0;
            buf_cnt_q   <= '0;
            pend_q      <= 1'b0;
            hi_q        <= '0;
            line_end_q  <= 1'b0;
        end else begin
            act_q       <= act_d;
            stb_q       <= stb_d;
            data_q      <= data_d;
            width_q     <= width_d;
            height_q    <= height_d;
            unpack_q    <= unpack_d;
            pixel_cnt_q <= pixel_cnt_d;
            line_cnt_q  <= line_cnt_d;
            buf_cnt_q   <= buf_cnt_d;
            pend_q      <= pend_d;
            hi_q        <= hi_d;
            line_end_q  <= line_end_d;
        end
    end

    assign o_fifo_act  = act_q;
    assign o_fifo_stb  = stb_q;
    assign o_fifo_data = data_q;

endmodule

// File: tb/tb_nh_lcd_line_feeder.sv
// Directed bench for nh_lcd_line_feeder: vector table of single-line frames
// plus hand-written multi-line, buffer-split, stall, random-valid and reset sequences.
module tb_nh_lcd_line_feeder;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic [31:0] i_image_width;
    logic [31:0] i_image_height;
    logic        i_unpack_pixels;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [31:0] i_pix_data;
    logic [1:0]  i_fifo_rdy;
    logic [1:0]  o_fifo_act;
    logic        o_fifo_stb;
    logic [23:0] i_fifo_size;
    logic [24:0] o_fifo_data;
    logic        o_frame_done;
    logic        o_busy;

    nh_lcd_line_feeder #(.DATAS_WIDTH(24)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_image_width   (i_image_width),
        .i_image_height  (i_image_height),
        .i_unpack_pixels (i_unpack_pixels),
        .i_pix_valid     (i_pix_valid),
        .o_pix_ready     (o_pix_ready),
        .i_pix_data      (i_pix_data),
        .i_fifo_rdy      (i_fifo_rdy),
        .o_fifo_act      (o_fifo_act),
        .o_fifo_stb      (o_fifo_stb),
        .i_fifo_size     (i_fifo_size),
        .o_fifo_data     (o_fifo_data),
        .o_frame_done    (o_frame_done),
        .o_busy          (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [31:0] src [0:127];
    logic [24:0] log_data [0:127];
    logic [1:0]  log_act [0:127];
    int n_stb, n_acc, n_rel, n_fd, n_extra, bad_hold, bad_act, grant_delay;
    bit done;

    typedef struct {
        logic [31:0] word;
        logic        unp;
        logic [24:0] exp0;
        logic [24:0] exp1;
    } vec_t;

    vec_t vecs [0:4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int w, input int h, input logic unp, input logic [23:0] size,
                             input logic [1:0] rdy0, input bit drain, input bit rnd, input int hold);
        logic [1:0] prev_act;
        logic [1:0] rdy_cur;
        int idx;
        n_stb = 0; n_acc = 0; n_rel = 0; n_fd = 0; n_extra = 0;
        bad_hold = 0; bad_act = 0; grant_delay = -1; done = 0; idx = 0;
        @(negedge clk);
        i_image_width   = w;
        i_image_height  = h;
        i_unpack_pixels = unp;
        i_fifo_size     = size;
        rdy_cur         = (hold > 0) ? 2'b00 : rdy0;
        i_fifo_rdy      = rdy_cur;
        i_enable        = 1'b1;
        i_pix_valid     = 1'b0;
        prev_act        = o_fifo_act;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            i_enable = 1'b0;
            if (o_fifo_stb) begin
                if (n_stb < 128) begin
                    log_data[n_stb] = o_fifo_data;
                    log_act[n_stb]  = o_fifo_act;
                end
                if (o_fifo_act == 2'b00) bad_act++;
                n_stb++;
            end
            if (prev_act != 2'b00 && o_fifo_act == 2'b00) begin
                n_rel++;
                if (drain) rdy_cur = rdy_cur & ~prev_act;
            end
            prev_act = o_fifo_act;
            if (cyc < hold) begin
                if (o_fifo_act != 2'b00 || o_fifo_stb || !o_busy) bad_hold++;
            end else if (cyc == hold && hold > 0) begin
                rdy_cur = rdy0;
            end else if (hold > 0 && grant_delay < 0 && o_fifo_act != 2'b00) begin
                grant_delay = cyc - hold;
            end
            i_fifo_rdy = rdy_cur;
            if (o_frame_done) begin
                n_fd++;
                done = 1;
            end
            i_pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_pix_data  = src[idx % 128];
            if (i_pix_valid && o_pix_ready) begin
                idx++;
                n_acc++;
            end
            if (done) break;
        end
        i_pix_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_frame_done || o_fifo_stb) n_extra++;
        end
        chk("frame_completes", done, 1);
    endtask

    initial begin
        int errs;
        int lasts;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        i_enable = 1'b0;
        i_image_width = 0;
        i_image_height = 0;
        i_unpack_pixels = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data = '0;
        i_fifo_rdy = 2'b00;
        i_fifo_size = 24'd64;

        vecs[0] = '{32'h0012_3456, 1'b0, 25'h112_3456, 25'h0};
        vecs[1] = '{32'hFF00_AA55, 1'b0, 25'h100_AA55, 25'h0};
        vecs[2] = '{32'hFFFF_F800, 1'b1, 25'h0FF_0000, 25'h1FF_FFFF};
        vecs[3] = '{32'h001F_07E0, 1'b1, 25'h000_FF00, 25'h100_00FF};
        vecs[4] = '{32'h0841_8410, 1'b1, 25'h084_8284, 25'h108_0808};

        repeat (3) @(negedge clk);
        chk("rst_act", o_fifo_act, 0);
        chk("rst_stb", o_fifo_stb, 0);
        chk("rst_data", o_fifo_data, 0);
        chk("rst_ready", o_pix_ready, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;

        // Enable with zero width must not start a frame.
        @(negedge clk);
        i_image_width = 0; i_image_height = 1; i_enable = 1'b1;
        @(negedge clk);
        chk("zero_width_idle", o_busy, 0);
        i_enable = 1'b0;

        for (int v = 0; v < 5; v++) begin
            src[0] = vecs[v].word;
            run_frame(vecs[v].unp ? 2 : 1, 1, vecs[v].unp, 24'd64, 2'b01, 0, 0, 0);
            chk($sformatf("vec%0d_strobes", v), n_stb, vecs[v].unp ? 2 : 1);
            chk($sformatf("vec%0d_pix0", v), log_data[0], vecs[v].exp0);
            if (vecs[v].unp) chk($sformatf("vec%0d_pix1", v), log_data[1], vecs[v].exp1);
        end

        // Two packed lines into alternating buffers.
        for (int i = 0; i < 8; i++) src[i] = 32'h00AA_BB00 + 32'(i);
        run_frame(4, 2, 1'b0, 24'd64, 2'b11, 1, 0, 0);
        chk("pk_strobes", n_stb, 8);
        errs = 0; lasts = 0;
        for (int i = 0; i < 8; i++) begin
            if (log_data[i][23:0] != 24'hAABB00 + 24'(i)) errs++;
            if (log_data[i][24]) lasts++;
        end
        chk("pk_data", errs, 0);
        chk("pk_last_count", lasts, 2);
        chk("pk_last3", log_data[3][24], 1);
        chk("pk_last7", log_data[7][24], 1);
        chk("pk_act_line0", log_act[0], 2'b01);
        chk("pk_act_line1", log_act[4], 2'b10);
        chk("pk_frame_done", n_fd + n_extra, 1);
        chk("pk_no_stb_without_act", bad_act, 0);

        // Odd width in unpack mode drops the trailing upper half.
        src[0] = 32'hFFFF_F800;
        src[1] = 32'h1234_07E0;
        run_frame(3, 1, 1'b1, 24'd64, 2'b01, 0, 0, 0);
        chk("odd_strobes", n_stb, 3);
        chk("odd_pix0", log_data[0], 25'h0FF_0000);
        chk("odd_pix1", log_data[1], 25'h0FF_FFFF);
        chk("odd_pix2", log_data[2], 25'h100_FF00);
        chk("odd_words", n_acc, 2);

        // Line split across two buffers of capacity 4.
        for (int i = 0; i < 6; i++) src[i] = 32'h0010_2030 + 32'(i);
        run_frame(6, 1, 1'b0, 24'd4, 2'b11, 1, 0, 0);
        chk("split_strobes", n_stb, 6);
        chk("split_releases", n_rel, 2);
        chk("split_act_first", log_act[3], 2'b01);
        chk("split_act_second", log_act[4], 2'b10);
        lasts = 0;
        for (int i = 0; i < 5; i++) if (log_data[i][24]) lasts++;
        chk("split_no_early_last", lasts, 0);
        chk("split_last", log_data[5], 25'h110_2035);

        // No buffer free for 10 cycles after enable.
        for (int i = 0; i < 2; i++) src[i] = 32'h0000_0101 * 32'(i + 1);
        run_frame(2, 1, 1'b0, 24'd64, 2'b01, 0, 0, 10);
        chk("hold_quiet", bad_hold, 0);
        chk("hold_grant_delay", grant_delay, 1);
        chk("hold_strobes", n_stb, 2);

        // Random valid: every accepted word yields exactly one strobe, in order.
        for (int i = 0; i < 32; i++) src[i] = 32'($urandom) & 32'h00FF_FFFF;
        run_frame(16, 2, 1'b0, 24'd64, 2'b01, 0, 1, 0);
        chk("rnd_accepted", n_acc, 32);
        chk("rnd_strobes", n_stb, n_acc);
        errs = 0;
        for (int i = 0; i < 32; i++) if (log_data[i][23:0] != src[i][23:0]) errs++;
        chk("rnd_data", errs, 0);

        // Reset in the middle of a line, then a fresh frame.
        @(negedge clk);
        i_image_width = 8; i_image_height = 1; i_unpack_pixels = 1'b0;
        i_fifo_size = 24'd64; i_fifo_rdy = 2'b01; i_enable = 1'b1;
        i_pix_data = 32'h0055_6677; i_pix_valid = 1'b1;
        repeat (6) @(negedge clk);
        i_enable = 1'b0;
        chk("mid_busy_before_rst", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        i_pix_valid = 1'b0;
        chk("mid_rst_act", o_fifo_act, 0);
        chk("mid_rst_stb", o_fifo_stb, 0);
        chk("mid_rst_data", o_fifo_data, 0);
        chk("mid_rst_ready", o_pix_ready, 0);
        chk("mid_rst_busy", o_busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) src[i] = 32'h0000_0A00 + 32'(i);
        run_frame(3, 1, 1'b0, 24'd64, 2'b01, 0, 0, 0);
        chk("post_rst_strobes", n_stb, 3);
        chk("post_rst_last", log_data[2], 25'h100_0A02);
        chk("post_rst_first", log_data[0], 25'h000_0A00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
